// File: rtl/adder_pkg.sv
// Shared types and limits for the serial word adder and its slice adder.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_t;

  localparam int MAX_SLICE_WIDTH = 8;

endpackage

// File: rtl/carry_look_ahead_adder.sv
// Single-slice adder: carries computed in flattened look-ahead form from
// generate/propagate terms rather than rippled bit by bit.
module carry_look_ahead_adder #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  carry_in,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  carry_out
);

  logic [DATA_WIDTH-1:0] gen;
  logic [DATA_WIDTH-1:0] prop;
  logic [DATA_WIDTH:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]carry_in
  always_comb begin
    logic cv;
    logic pv;
    carry    = '0;
    cv       = 1'b0;
    pv       = 1'b0;
    carry[0] = carry_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      cv = gen[i];
      pv = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        cv = cv | (pv & gen[j]);
        pv = pv & prop[j];
      end
      carry[i+1] = cv | (pv & carry_in);
    end
  end

  assign sum       = prop ^ carry[DATA_WIDTH-1:0];
  assign carry_out = carry[DATA_WIDTH];

endmodule

// File: rtl/serial_word_adder.sv
// Sequences wide operands LSB-first through one slice adder, one slice per
// cycle, with the inter-slice carry held in a register.
module serial_word_adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_WIDTH = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [OPERAND_WIDTH-1:0] a_in,
  input  logic [OPERAND_WIDTH-1:0] b_in,
  input  logic                     sub_in,
  input  logic                     carry_in,
  input  logic                     in_valid_in,
  output logic                     in_ready_out,
  output logic [OPERAND_WIDTH-1:0] sum_out,
  output logic                     carry_out,
  output logic                     overflow_out,
  output logic                     out_valid_out,
  input  logic                     out_ready_in,
  output sadd_state_t              state_out
);

  localparam int WORDS = OPERAND_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_SLICE_WIDTH) begin : g_bad_width
    $error("serial_word_adder: DATA_WIDTH must be 1..%0d", MAX_SLICE_WIDTH);
  end
  if (OPERAND_WIDTH % DATA_WIDTH != 0) begin : g_bad_ratio
    $error("serial_word_adder: OPERAND_WIDTH must be a multiple of DATA_WIDTH");
  end

  sadd_state_t state_q, state_d;
  logic accept, run_step, last_slice;

  logic [OPERAND_WIDTH-1:0] a_r, b_r, sum_r;
  logic                     carry_r, carry_q, ovf_q;
  logic [IDX_W-1:0]         idx_q;

  logic [DATA_WIDTH-1:0] slice_sum;
  logic                  slice_carry;

  carry_look_ahead_adder #(.DATA_WIDTH(DATA_WIDTH)) u_slice_add (
    .a         (a_r[idx_q*DATA_WIDTH +: DATA_WIDTH]),
    .b         (b_r[idx_q*DATA_WIDTH +: DATA_WIDTH]),
    .carry_in  (carry_r),
    .sum       (slice_sum),
    .carry_out (slice_carry)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; valid never waits on ready, and DONE holds results until taken.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    run_step   = 1'b0;
    last_slice = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_in) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        run_step   = 1'b1;
        last_slice = (idx_q == LAST_IDX);
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        if (out_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_r     <= a_in;
      b_r     <= sub_in ? ~b_in : b_in;
      carry_r <= sub_in | carry_in;
      idx_q   <= '0;
    end else if (run_step) begin
      sum_r[idx_q*DATA_WIDTH +: DATA_WIDTH] <= slice_sum;
      carry_r <= slice_carry;
      if (last_slice) begin
        // slice_sum MSB is the final result MSB on the last slice
        carry_q <= slice_carry;
        ovf_q   <= (a_r[OPERAND_WIDTH-1] == b_r[OPERAND_WIDTH-1]) &
                   (slice_sum[DATA_WIDTH-1] != a_r[OPERAND_WIDTH-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign in_ready_out  = (state_q == IDLE) & ~rst_in;
  assign out_valid_out = (state_q == DONE);
  assign sum_out       = sum_r;
  assign carry_out     = carry_q;
  assign overflow_out  = ovf_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder at DATA_WIDTH=8, OPERAND_WIDTH=32.
module tb_serial_word_adder;
  import adder_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] a_in, b_in;
  logic        sub_in, carry_in, in_valid_in;
  logic        in_ready_out;
  logic [31:0] sum_out;
  logic        carry_out, overflow_out, out_valid_out;
  logic        out_ready_in;
  sadd_state_t state_out;

  int checks = 0;
  int errors = 0;

  serial_word_adder #(.DATA_WIDTH(8), .OPERAND_WIDTH(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .a_in          (a_in),
    .b_in          (b_in),
    .sub_in        (sub_in),
    .carry_in      (carry_in),
    .in_valid_in   (in_valid_in),
    .in_ready_out  (in_ready_out),
    .sum_out       (sum_out),
    .carry_out     (carry_out),
    .overflow_out  (overflow_out),
    .out_valid_out (out_valid_out),
    .out_ready_in  (out_ready_in),
    .state_out     (state_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // driver: present one operation for a single edge
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c);
    @(negedge clk_in);
    a_in = a; b_in = b; sub_in = s; carry_in = c; in_valid_in = 1'b1;
    @(posedge clk_in);
    #1 in_valid_in = 1'b0;
  endtask

  // edges from the accept edge until out_valid_out is seen; -1 on timeout
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_in);
      #1;
      if (out_valid_out) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; in_valid_in = 1'b0; out_ready_in = 1'b1;
    a_in = '0; b_in = '0; sub_in = 1'b0; carry_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    checks++; if (in_ready_out !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready_out); end
    checks++; if ({sum_out, carry_out, overflow_out, out_valid_out} !== 35'd0) begin errors++; $display("FAIL reset_outputs got %h %b %b %b exp 0", sum_out, carry_out, overflow_out, out_valid_out); end
    checks++; if (state_out !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_out, IDLE); end
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    checks++; if (in_ready_out !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready_out); end
  endtask

  // one full add/sub with latency, flags, and single-cycle valid pulse
  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, input logic [31:0] exp_sum,
                         input logic exp_c, input logic exp_v);
    int lat;
    drive_op(a, b, s, c);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s_latency got %0d exp 4", name, lat); end
    checks++; if (sum_out !== exp_sum) begin errors++; $display("FAIL %s_sum got %h exp %h", name, sum_out, exp_sum); end
    checks++; if (carry_out !== exp_c) begin errors++; $display("FAIL %s_carry got %b exp %b", name, carry_out, exp_c); end
    checks++; if (overflow_out !== exp_v) begin errors++; $display("FAIL %s_ovf got %b exp %b", name, overflow_out, exp_v); end
    @(posedge clk_in); #1;
    checks++; if (out_valid_out !== 1'b0 || in_ready_out !== 1'b1) begin errors++; $display("FAIL %s_pulse got valid %b ready %b exp 0 1", name, out_valid_out, in_ready_out); end
  endtask

  task automatic test_back_pressure();
    int lat;
    out_ready_in = 1'b0;
    drive_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", lat); end
    a_in = 32'hAAAA_AAAA; b_in = 32'h5555_5555; in_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in); #1;
      checks++;
      if (out_valid_out !== 1'b1 || in_ready_out !== 1'b0 || sum_out !== 32'h0000_0030 ||
          carry_out !== 1'b0 || overflow_out !== 1'b0 || state_out !== DONE) begin
        errors++;
        $display("FAIL bp_hold_%0d got valid %b ready %b sum %h exp 1 0 00000030", i, out_valid_out, in_ready_out, sum_out);
      end
    end
    in_valid_in = 1'b0; out_ready_in = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (in_ready_out !== 1'b1 || out_valid_out !== 1'b0) begin errors++; $display("FAIL bp_release got ready %b valid %b exp 1 0", in_ready_out, out_valid_out); end
    checks++; if (sum_out !== 32'h0000_0030) begin errors++; $display("FAIL bp_retain_sum got %h exp 00000030", sum_out); end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    drive_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    checks++; if ({sum_out, carry_out, overflow_out, out_valid_out, in_ready_out} !== 36'd0) begin errors++; $display("FAIL midrst_outputs got %h %b %b %b %b exp 0", sum_out, carry_out, overflow_out, out_valid_out, in_ready_out); end
    @(posedge clk_in); #1 rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_in); #1;
      if (out_valid_out) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_valid got %0d exp 0", seen); end
    checks++; if (state_out !== IDLE || sum_out !== 32'd0) begin errors++; $display("FAIL midrst_idle got state %0d sum %h exp %0d 0", state_out, sum_out, IDLE); end
    test_op("after_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add_ff", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    test_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    test_op("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_op("sub",    32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    test_back_pressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
